// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - parametrised register file with per-register busy scoreboard
// Optional same-edge read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int MON_REG  = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      RA,
    input  logic [ADDR_W-1:0]      RB,
    output logic [WIDTH-1:0]       BusA,
    output logic [WIDTH-1:0]       BusB,
    output logic                   busyA,
    output logic                   busyB,
    input  logic                   enableWrite,
    input  logic [ADDR_W-1:0]      RW,
    input  logic [WIDTH-1:0]       BusW,
    input  logic                   enableReserve,
    input  logic [ADDR_W-1:0]      RR,
    output logic [WIDTH-1:0]       monR,
    output logic [(2**ADDR_W)-1:0] busyVec
);

    localparam int NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] MON_IDX = ADDR_W'(MON_REG);
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [WIDTH-1:0]    regs     [NUM_REGS];
    logic [WIDTH-1:0]    regs_nxt [NUM_REGS];
    logic [WIDTH-1:0]    src_regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [NUM_REGS-1:0] src_busy;

    logic                wr_ok;
    logic                rs_ok;
    logic [WIDTH-1:0]    rd_a;
    logic [WIDTH-1:0]    rd_b;
    logic [WIDTH-1:0]    rd_mon;
    logic                rd_busy_a;
    logic                rd_busy_b;
    logic [NUM_REGS-1:0] rd_vec;

    // Reserve is applied after the write so a same-edge producer keeps the register busy.
    always_comb begin
        wr_ok    = enableWrite   && !(HAS_ZERO && (RW == '0));
        rs_ok    = enableReserve && !(HAS_ZERO && (RR == '0));
        regs_nxt = regs;
        busy_nxt = busy;
        if (wr_ok) begin
            regs_nxt[RW] = BusW;
            busy_nxt[RW] = 1'b0;
        end
        if (rs_ok) begin
            busy_nxt[RR] = 1'b1;
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        src_regs = regs_nxt;
        src_busy = busy_nxt;
    end
`else
    always_comb begin
        src_regs = regs;
        src_busy = busy;
    end
`endif

    always_comb begin
        rd_a      = src_regs[RA];
        rd_b      = src_regs[RB];
        rd_mon    = src_regs[MON_IDX];
        rd_busy_a = src_busy[RA];
        rd_busy_b = src_busy[RB];
        rd_vec    = src_busy;
        if (HAS_ZERO) begin
            if (RA == '0) begin
                rd_a      = '0;
                rd_busy_a = 1'b0;
            end
            if (RB == '0) begin
                rd_b      = '0;
                rd_busy_b = 1'b0;
            end
            if (MON_IDX == '0) begin
                rd_mon = '0;
            end
            rd_vec[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs    <= '{default: '0};
            busy    <= '0;
            BusA    <= '0;
            BusB    <= '0;
            busyA   <= 1'b0;
            busyB   <= 1'b0;
            monR    <= '0;
            busyVec <= '0;
        end else begin
            regs    <= regs_nxt;
            busy    <= busy_nxt;
            BusA    <= rd_a;
            BusB    <= rd_b;
            busyA   <= rd_busy_a;
            busyB   <= rd_busy_b;
            monR    <= rd_mon;
            busyVec <= rd_vec;
        end
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised successor to the processor's 8×16 register file. Generalises width and depth and adds a per-register busy scoreboard so the decode stage can detect RAW hazards. Replaces the level-sensitive write with a synchronous, clock-edge write port. Keeps two registered read ports plus a monitor port, and sits between decode (reads, reserve) and write-back (write).

## Interface
Parameters:
- WIDTH, 16, data width of every register
- ADDR_W, 3, register index width; NUM_REGS = 2**ADDR_W
- ZERO_REG, 1, when 1, register 0 reads 0 and ignores writes/reserves
- MON_REG, 7, index of register driven on monR

Ports (one clock `clk`; reset `reset` is synchronous, active-high):
- clk  in  1  rising-edge clock for all state
- reset  in  1  synchronous active-high reset
- RA, RB  in  ADDR_W  read addresses, sampled at posedge
- BusA, BusB  out  WIDTH  registered read data
- busyA, busyB  out  1  registered busy flag of RA / RB
- enableWrite  in  1  write strobe
- RW  in  ADDR_W  write address
- BusW  in  WIDTH  write data
- enableReserve  in  1  mark a register as having a pending producer
- RR  in  ADDR_W  reserve address
- monR  out  WIDTH  registered value of register MON_REG
- busyVec  out  NUM_REGS  registered busy bit per register

## Operation
- Storage: NUM_REGS × WIDTH registers and NUM_REGS busy bits; all updated only at posedge clk.
- Write: if enableWrite, and not (ZERO_REG and RW==0), regs[RW] <= BusW and busy[RW] <= 0.
- Reserve: if enableReserve, and not (ZERO_REG and RR==0), busy[RR] <= 1.
- Same-edge write and reserve to the same register: data is written; busy ends 1 (the newer producer wins).
- Write to a non-busy register is legal: data updates, busy stays 0.
- Reserve of an already-busy register: busy stays 1, no error.
- Reads: at each posedge, BusA/BusB/busyA/busyB load from RA/RB; monR loads regs[MON_REG]; busyVec loads the busy bits.
  - With ZERO_REG=1, index 0 always yields data 0, busy 0.
- Read-during-write to the same address: governed by the macro in Configuration.
- Reset (reset=1 at posedge):
  - All registers and all busy bits go to 0.
  - BusA, BusB, busyA, busyB, monR, busyVec go to 0.
  - Reset overrides a simultaneous write/reserve.
  - Reset mid-pipeline discards all pending reservations.

## Timing
- Write and reserve take effect at the posedge where they are sampled; visible in storage from that edge.
- Read latency: 1 cycle. RA presented before edge N gives BusA valid after edge N.
- Without bypass, a write at edge N is first readable at edge N+1.
- monR and busyVec track storage with the same 1-cycle lag, or 0-lag with bypass.
- No combinational path from any input to any output.
- First output values after reset deassertion are valid one edge later.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- Defined: a read (RA, RB or MON_REG) of the register written at the same edge returns BusW. busyA/busyB/busyVec return the post-update busy state, i.e. write clears busy and reserve sets it, with same-edge reserve winning.
- Undefined: reads return the pre-edge register value and pre-edge busy state. The hazard unit must then stall one extra cycle.

## Test plan
- Reset then read all indices: BusA=BusB=0, busy=0, monR=0 for every RA/RB.
- Write RW=5, BusW=16'h00AB, then read RA=5 next edge: BusA=16'h00AB.
  - Same-edge RA=5 gives 16'h00AB with bypass, old value 0 without.
- ZERO_REG=1: write RW=0, BusW=16'hFFFF, and reserve RR=0. A later read of RA=0 gives BusA=0, busyA=0.
- Reserve RR=3; next read busyA(RA=3)=1. Write RW=3, BusW=16'h1234; next read busyA=0, BusA=16'h1234.
  - Same-edge write RW=3 plus reserve RR=3 leaves busyVec[3]=1.
- Write RW=7 with 16'h000A, then check monR=16'h000A after one edge (same edge with bypass).
- Reserve RR=2 and write RW=6 with 16'h0F0F, then assert reset. All busyVec=0, reg6 reads 0.
  - reset overriding a simultaneous write: RW=4 reads 0.
